obstacle_rng: RTL and testbench



---
 rtl/rng_pkg.sv | 19 +
 rtl/lfsr16_galois.sv | 38 +++
 rtl/obstacle_rng.sv | 134 +++++++++++++
 tb/tb_obstacle_rng.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared definitions for the LFSR-based random sources: width, taps, default
// seed, draw/hold state encoding and the single-step Galois update.
package rng_pkg;

  localparam int                LFSR_W       = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    DRAW = 1'b0,
    HOLD = 1'b1
  } rng_state_e;

  // Right-shifting Galois step; a nonzero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] lfsr);
    lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit Galois LFSR register: load has priority over enable, otherwise holds.
// Kept free of any consumer logic so other random sources can reuse it.
module lfsr16_galois
  import rng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_val_i;
    end else if (enable_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/obstacle_rng.sv
// Uniform random values in [0, MOD-1] via LFSR rejection sampling with a bounded
// retry fallback. Optional rejection statistics: define OBSTACLE_RNG_STATS_EN.
module obstacle_rng
  import rng_pkg::*;
#(
  parameter int                MOD       = 3,
  parameter int                VW        = 2,
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
  parameter int                MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VW-1:0]     out_value,
`ifdef OBSTACLE_RNG_STATS_EN
  output logic [15:0]       reject_cnt,
`endif
  output rng_state_e        dbg_state_o
);

  localparam int            TW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);
  localparam logic [VW-1:0] MOD_V    = VW'(MOD);

  rng_state_e        state_q, state_d;
  logic [TW-1:0]     tries_q, tries_d;
  logic              valid_q, valid_d;
  logic [VW-1:0]     value_q, value_d;
  logic [LFSR_W-1:0] lfsr_cur;
  logic [LFSR_W-1:0] seed_val;
  logic [VW-1:0]     cand;
  logic              cand_ok;
  logic              lfsr_en;
  logic              lfsr_ld;

  // A zero seed would lock the LFSR, so it is replaced by the default seed.
  assign seed_val = (seed_i == '0) ? SEED : seed_i;
  assign cand     = VW'(lfsr_next(lfsr_cur));
  assign cand_ok  = (32'(cand) < 32'(MOD));

  lfsr16_galois #(
    .RESET_VAL (SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable_i   (lfsr_en),
    .load_i     (lfsr_ld),
    .load_val_i (seed_val),
    .state_o    (lfsr_cur)
  );

  // Handshake: out_value is offered while out_valid=1 and held stable until a
  // cycle with out_valid && out_ready; out_ready while out_valid=0 is ignored.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    valid_d = valid_q;
    value_d = value_q;
    lfsr_en = 1'b0;
    lfsr_ld = 1'b0;
    if (seed_load) begin
      lfsr_ld = 1'b1;
      valid_d = 1'b0;
      tries_d = '0;
      state_d = DRAW;
    end else begin
      case (state_q)
        DRAW: begin
          lfsr_en = 1'b1;
          if (cand_ok) begin
            value_d = cand;
            valid_d = 1'b1;
            tries_d = '0;
            state_d = HOLD;
          end else if (tries_q == LAST_TRY) begin
            value_d = cand - MOD_V;
            valid_d = 1'b1;
            tries_d = '0;
            state_d = HOLD;
          end else begin
            tries_d = tries_q + 1'b1;
          end
        end
        HOLD: begin
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
            state_d = DRAW;
          end
        end
        default: state_d = DRAW;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= DRAW;
      tries_q <= '0;
      valid_q <= 1'b0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      valid_q <= valid_d;
      value_q <= value_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_value   = value_q;
  assign dbg_state_o = state_q;

`ifdef OBSTACLE_RNG_STATS_EN
  logic        rej;
  logic [15:0] rej_cnt_q;

  // Only retried candidates count; the fallback draw is not a rejection.
  assign rej = !seed_load && (state_q == DRAW) && !cand_ok && (tries_q != LAST_TRY);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rej_cnt_q <= '0;
    end else if (rej && (rej_cnt_q != 16'hFFFF)) begin
      rej_cnt_q <= rej_cnt_q + 16'd1;
    end
  end

  assign reject_cnt = rej_cnt_q;
`endif

endmodule

// File: tb/tb_obstacle_rng.sv
// Directed and randomised checks of obstacle_rng (MOD=3) plus a MAX_TRIES=1
// instance for the fallback path. Reject counter checked with OBSTACLE_RNG_STATS_EN.
module tb_obstacle_rng;
  import rng_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n   = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_i    = 16'h0;
  logic        out_ready = 1'b1;
  logic        out_ready2 = 1'b1;
  logic        out_valid, out_valid2;
  logic [1:0]  out_value, out_value2;
  rng_state_e  dbg_state, dbg_state2;
`ifdef OBSTACLE_RNG_STATS_EN
  logic [15:0] reject_cnt, reject_cnt2;
`endif

  obstacle_rng #(.MOD(3), .VW(2), .SEED(16'hACE1), .MAX_TRIES(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seed_load   (seed_load),
    .seed_i      (seed_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
`ifdef OBSTACLE_RNG_STATS_EN
    .reject_cnt  (reject_cnt),
`endif
    .dbg_state_o (dbg_state)
  );

  obstacle_rng #(.MOD(3), .VW(2), .SEED(16'hACE1), .MAX_TRIES(1)) dut_ft (
    .clk         (clk),
    .reset_n     (reset_n),
    .seed_load   (seed_load),
    .seed_i      (seed_i),
    .out_valid   (out_valid2),
    .out_ready   (out_ready2),
    .out_value   (out_value2),
`ifdef OBSTACLE_RNG_STATS_EN
    .reject_cnt  (reject_cnt2),
`endif
    .dbg_state_o (dbg_state2)
  );

  // ---------------- scoreboard state ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_q[$];
  int          exp_w[$];
  logic [15:0] m_lfsr;
  int          hist[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    seed_load = 1'b0;
    tick();
    reset_n   = 1'b1;
  endtask

  task automatic do_seed(input logic [15:0] s);
    seed_i    = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  // Wait (bounded) for a valid value, take it, and report idle cycles waited.
  task automatic get_val(input bit ft, output logic [1:0] v, output int waits);
    waits = 0;
    if (ft) out_ready2 = 1'b1;
    else    out_ready  = 1'b1;
    while (!(ft ? out_valid2 : out_valid) && waits < 40) begin
      tick();
      waits++;
    end
    v = ft ? out_value2 : out_value;
    tick();
  endtask

  task automatic drain(input bit ft, input string tag);
    logic [1:0] v;
    int         w;
    int         i;
    i = 0;
    while (exp_q.size() > 0) begin
      get_val(ft, v, w);
      check($sformatf("%s_val%0d", tag, i), {30'd0, v}, {30'd0, exp_q.pop_front()});
      check($sformatf("%s_wait%0d", tag, i), w, exp_w.pop_front());
      i++;
    end
  endtask

  task automatic load_default();
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1};
    exp_w = '{1, 1, 1, 1, 3};
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic draw_model(output logic [1:0] v);
    v = 2'd0;
    for (int t = 0; t < 8; t++) begin
      m_lfsr = model_step(m_lfsr);
      if (m_lfsr[1:0] != 2'd3) begin
        v = m_lfsr[1:0];
        return;
      end
    end
    v = 2'd0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random steps ----------------
  initial begin
    logic [1:0] v, e;
    int         w, hs, cyc;

    // Reset state and default-seed sequence 0,0,0,2,(reject x2),1
    out_ready = 1'b1;
    do_reset();
    check("rst_valid", out_valid, 1'b0);
    check("rst_value", {30'd0, out_value}, 32'd0);
    check("rst_state", dbg_state, DRAW);
    check("rst_lfsr", dut.lfsr_cur, 16'hACE1);
`ifdef OBSTACLE_RNG_STATS_EN
    check("rst_rejcnt", reject_cnt, 16'd0);
`endif
    load_default();
    drain(1'b0, "seq");
`ifdef OBSTACLE_RNG_STATS_EN
    check("seq_rejcnt", reject_cnt, 16'd2);
`endif

    // seed_load(0) during HOLD drops valid and restarts the default sequence
    out_ready = 1'b0;
    tick();
    check("hold_valid", out_valid, 1'b1);
    check("hold_state", dbg_state, HOLD);
    do_seed(16'h0000);
    check("seed_valid_drop", out_valid, 1'b0);
    check("seed_state", dbg_state, DRAW);
    check("seed_lfsr", dut.lfsr_cur, 16'hACE1);
    load_default();
    drain(1'b0, "reseed");
`ifdef OBSTACLE_RNG_STATS_EN
    check("reseed_rejcnt_kept", reject_cnt, 16'd4);
`endif

    // Nonzero seed: 0x1C4E -> 0x0E27 (rej), 0xB313 (rej), 0xED89 -> 1
    do_seed(16'h1C4E);
    exp_q = '{2'd1};
    exp_w = '{3};
    drain(1'b0, "seed1c4e");

    // Backpressure: value and LFSR frozen for 10 cycles
    out_ready = 1'b0;
    do_reset();
    tick();
    check("bp_first_valid", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_valid%0d", i), out_valid, 1'b1);
      check($sformatf("bp_value%0d", i), {30'd0, out_value}, 32'd0);
    end
    check("bp_lfsr_frozen", dut.lfsr_cur, 16'hE270);
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 1'b0);
    get_val(1'b0, v, w);
    check("bp_next_val", {30'd0, v}, 32'd0);
    check("bp_next_wait", w, 1);
    check("bp_next_lfsr", dut.lfsr_cur, 16'h7138);

    // Reset mid-DRAW (during a rejection) and mid-HOLD
    do_reset();
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd2};
    exp_w = '{1, 1, 1, 1};
    drain(1'b0, "pre_mid");
    tick();
    check("mid_draw_state", dbg_state, DRAW);
    do_reset();
    check("mid_draw_rst_valid", out_valid, 1'b0);
    check("mid_draw_rst_value", {30'd0, out_value}, 32'd0);
    check("mid_draw_rst_state", dbg_state, DRAW);
`ifdef OBSTACLE_RNG_STATS_EN
    check("mid_draw_rst_rejcnt", reject_cnt, 16'd0);
`endif
    exp_q = '{2'd0, 2'd0, 2'd0};
    exp_w = '{1, 1, 1};
    drain(1'b0, "after_draw_rst");
    out_ready = 1'b0;
    tick();
    check("mid_hold_value", {30'd0, out_value}, 32'd2);
    check("mid_hold_state", dbg_state, HOLD);
    do_reset();
    check("mid_hold_rst_valid", out_valid, 1'b0);
    check("mid_hold_rst_value", {30'd0, out_value}, 32'd0);
    check("mid_hold_rst_state", dbg_state, DRAW);
    load_default();
    drain(1'b0, "after_hold_rst");

    // MAX_TRIES=1: out-of-range candidates fall back to 0 with no retry cycle
    do_reset();
    check("ft_rst_valid", out_valid2, 1'b0);
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1};
    exp_w = '{1, 1, 1, 1, 1, 1, 1};
    drain(1'b1, "ft");

    // Random ready and reseeds, scoreboarded against the model
    do_reset();
    m_lfsr = 16'hACE1;
    hs = 0;
    cyc = 0;
    for (int k = 0; k < 4; k++) hist[k] = 0;
    while (hs < 10000 && cyc < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 299) == 0);
      seed_i    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
      if (out_valid && out_ready) begin
        draw_model(e);
        exp_q.push_back(e);
        check($sformatf("rand_hs%0d", hs), {30'd0, out_value}, {30'd0, exp_q.pop_front()});
        hist[out_value]++;
        hs++;
      end
      if (seed_load) m_lfsr = (seed_i == 16'h0) ? 16'hACE1 : seed_i;
      tick();
      cyc++;
    end
    seed_load = 1'b0;
    check("rand_hs_count", hs, 10000);
    check("rand_no_3", hist[3], 0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rand_dist%0d_in_band", k), (hist[k] >= 3133 && hist[k] <= 3533), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
